// File: rtl/pa_fdsu_iter_ctrl_pkg.sv
// pa_fdsu_iter_ctrl_pkg: shared FDSU constants and iteration FSM state encodings
package pa_fdsu_iter_ctrl_pkg;
  localparam int FLEN = 32;
  localparam int QBITS = 26;
  localparam int RW = FLEN;
  localparam int WW = 28;
  localparam int EW = 13;
  localparam int DW = 24;
  localparam logic [EW-1:0] BIAS = 13'd127;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/pa_fdsu_iter_step.sv
// pa_fdsu_iter_step: one restoring divide/sqrt step comparing 2W against 16*D or the trial root 4Q+2^(j+1)
module pa_fdsu_iter_step
  import pa_fdsu_iter_ctrl_pkg::*;
(
  input  logic [WW-1:0]    w,
  input  logic [QBITS-1:0] q,
  input  logic [4:0]       j,
  input  logic [DW-1:0]    d,
  input  logic             div,
  input  logic             sqrt,
  output logic [WW-1:0]    w_nxt,
  output logic             q_bit
);
  logic [WW:0] w2, trial, diff;
  assign w2 = {w, 1'b0};
  assign trial = div ? {1'b0, d, 4'b0000} : ({1'b0, q, 2'b00} | ((WW+1)'(1) << (j + 5'd1)));
  assign diff = w2 - trial;
  assign q_bit = (div || sqrt) && (w2 >= trial);
  assign w_nxt = q_bit ? WW'(diff) : WW'(w2);
endmodule

// File: rtl/pa_fdsu_iter_ctrl.sv
// pa_fdsu_iter_ctrl: FDSU EX2 stage running the bit-serial divide/sqrt recurrence and holding the result until ex3_ack
module pa_fdsu_iter_ctrl
  import pa_fdsu_iter_ctrl_pkg::*;
(
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             ex1_pipedown,
  input  logic             ex1_div,
  input  logic             ex1_sqrt,
  input  logic [RW-1:0]    ex1_remainder,
  input  logic [DW-1:0]    ex1_divisor,
  input  logic [EW-1:0]    ex1_expnt_adder_op0,
  input  logic [EW-1:0]    ex1_expnt_adder_op1,
  input  logic             ex1_result_sign,
  input  logic [2:0]       ex1_rm,
  input  logic             ex1_of_result_lfn,
  input  logic             fdsu_kill,
  input  logic             ex3_ack,
  output logic             iter_busy,
  output logic             iter_done_vld,
  output logic [QBITS-1:0] iter_quotient,
  output logic             iter_sticky,
  output logic [EW-1:0]    iter_expnt,
  output logic             iter_result_sign,
  output logic [2:0]       iter_rm,
  output logic             iter_of_result_lfn,
  output logic             iter_div
);
  logic [1:0] state;
  logic [4:0] cnt;
  logic [WW-1:0] w, w_nxt;
  logic [DW-1:0] d;
  logic sqrt_op, q_bit, start;
  logic [EW-1:0] div_expnt, sqrt_sum, expnt_nxt;
  logic [RW-WW-1:0] unused_rem;
  assign unused_rem = ex1_remainder[RW-1:WW];
  assign start = ex1_pipedown && (state == IDLE || (state == DONE && ex3_ack));
  assign div_expnt = ex1_expnt_adder_op0 - ex1_expnt_adder_op1 + BIAS;
  assign sqrt_sum = ex1_expnt_adder_op0 + ex1_expnt_adder_op1;
  assign expnt_nxt = ex1_div ? div_expnt : ex1_sqrt ? {sqrt_sum[EW-1], sqrt_sum[EW-1:1]} : '0;
  assign iter_busy = state != IDLE;
  assign iter_done_vld = state == DONE;
  assign iter_sticky = (iter_div || sqrt_op) && (|w);
  pa_fdsu_iter_step u_step (
    .w     (w),
    .q     (iter_quotient),
    .j     (cnt),
    .d     (d),
    .div   (iter_div),
    .sqrt  (sqrt_op),
    .w_nxt (w_nxt),
    .q_bit (q_bit)
  );
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state <= IDLE;
      cnt <= '0;
      w <= '0;
      d <= '0;
      sqrt_op <= 1'b0;
      iter_quotient <= '0;
      iter_expnt <= '0;
      iter_result_sign <= 1'b0;
      iter_rm <= '0;
      iter_of_result_lfn <= 1'b0;
      iter_div <= 1'b0;
    end else if (fdsu_kill) begin
      state <= IDLE;
    end else if (start) begin
      state <= ITER;
      cnt <= 5'(QBITS - 1);
      w <= ex1_remainder[WW-1:0];
      d <= ex1_divisor;
      sqrt_op <= ex1_sqrt;
      iter_quotient <= '0;
      iter_expnt <= expnt_nxt;
      iter_result_sign <= ex1_result_sign;
      iter_rm <= ex1_rm;
      iter_of_result_lfn <= ex1_of_result_lfn;
      iter_div <= ex1_div;
    end else if (state == ITER) begin
      w <= w_nxt;
      iter_quotient[cnt] <= q_bit;
      state <= (cnt == 5'd0) ? DONE : ITER;
      cnt <= cnt - {4'b0000, cnt != 5'd0};
    end else if (iter_done_vld && ex3_ack) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_pa_fdsu_iter_ctrl.sv
// tb_pa_fdsu_iter_ctrl: scoreboard bench for the FDSU iteration stage
module tb_pa_fdsu_iter_ctrl;
  typedef struct packed {
    logic [25:0] q;
    logic        sticky;
    logic [12:0] e;
    logic        sign;
    logic [2:0]  rm;
    logic        lfn;
    logic        div;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pd = 1'b0, op_div = 1'b0, op_sqrt = 1'b0, sign = 1'b0, lfn = 1'b0, kill = 1'b0, ack = 1'b0;
  logic [31:0] rem = '0;
  logic [23:0] dv = '0;
  logic [12:0] op0 = '0, op1 = '0;
  logic [2:0] rm = '0;
  logic busy, vld, sticky, osign, olfn, odiv;
  logic [25:0] q;
  logic [12:0] e;
  logic [2:0] orm;
  res_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] dir_r0 [4] = '{32'h4000000, 32'h4000000, 32'h2000000, 32'h4000000};
  logic [23:0] dir_d [4] = '{24'h800000, 24'hC00000, 24'h000000, 24'h000000};
  logic dir_div [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [12:0] dir_a [4] = '{13'd127, 13'd127, 13'd129, 13'd128};
  logic [25:0] dir_q [4] = '{26'h2000000, 26'h1555555, 26'h2000000, 26'h2D413CC};
  logic dir_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [12:0] dir_e [4] = '{13'd127, 13'd127, 13'd128, 13'd127};
  always #5 clk = ~clk;
  pa_fdsu_iter_ctrl dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (rst_n),
    .ex1_pipedown        (pd),
    .ex1_div             (op_div),
    .ex1_sqrt            (op_sqrt),
    .ex1_remainder       (rem),
    .ex1_divisor         (dv),
    .ex1_expnt_adder_op0 (op0),
    .ex1_expnt_adder_op1 (op1),
    .ex1_result_sign     (sign),
    .ex1_rm              (rm),
    .ex1_of_result_lfn   (lfn),
    .fdsu_kill           (kill),
    .ex3_ack             (ack),
    .iter_busy           (busy),
    .iter_done_vld       (vld),
    .iter_quotient       (q),
    .iter_sticky         (sticky),
    .iter_expnt          (e),
    .iter_result_sign    (osign),
    .iter_rm             (orm),
    .iter_of_result_lfn  (olfn),
    .iter_div            (odiv)
  );
  always @(posedge clk)
    if (rst_n && pd && !kill)
      assert (!busy || (vld && ack)) else $error("FAIL protocol: pipedown while stage occupied");
  function automatic res_t model(input logic md, input logic ms, input logic [31:0] r0, input logic [23:0] dd,
                                 input logic [12:0] a, input logic [12:0] b, input logic sg, input logic [2:0] m, input logic lf);
    longint unsigned n, g, t;
    logic [12:0] s;
    res_t r;
    r = '0;
    r.sign = sg;
    r.rm = m;
    r.lfn = lf;
    r.div = md;
    if (md) begin
      n = longint'(r0) << 22;
      r.q = 26'(n / longint'(dd));
      r.sticky = (n % longint'(dd)) != 0;
      r.e = 13'(int'(a) - int'(b) + 127);
    end else if (ms) begin
      n = longint'(r0) << 25;
      g = 0;
      for (int i = 25; i >= 0; i--) begin
        t = g | (64'd1 << i);
        if (t * t <= n) g = t;
      end
      r.q = 26'(g);
      r.sticky = n != g * g;
      s = a + b;
      r.e = 13'($signed(s) >>> 1);
    end
    return r;
  endfunction
  function automatic res_t got();
    return res_t'({q, sticky, e, osign, orm, olfn, odiv});
  endfunction
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic md, input logic ms, input logic [31:0] r0, input logic [23:0] dd,
                       input logic [12:0] a, input logic [12:0] b);
    op_div = md;
    op_sqrt = ms;
    rem = r0;
    dv = dd;
    op0 = a;
    op1 = b;
    sign = 1'($urandom);
    rm = 3'($urandom);
    lfn = 1'($urandom);
    pd = 1'b1;
    sb.push_back(model(md, ms, r0, dd, a, b, sign, rm, lfn));
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!vld && n < 60) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    pd = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, vld, got()} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %h want 0", {busy, vld, got()});
    end
    pd = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, vld} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release busy/vld got %b want 00", {busy, vld});
    end
  endtask
  task automatic test_directed();
    int n;
    res_t x;
    for (int i = 0; i < 4; i++) begin
      issue(dir_div[i], !dir_div[i], dir_r0[i], dir_d[i], dir_a[i], 13'd127);
      tick();
      pd = 1'b0;
      wait_done(n);
      checks++;
      if (n !== 26) begin
        errors++;
        $display("FAIL dir%0d latency got %0d want 26", i, n);
      end
      checks++;
      if ({q, sticky, e} !== {dir_q[i], dir_s[i], dir_e[i]}) begin
        errors++;
        $display("FAIL dir%0d q/sticky/e got %h/%b/%0d want %h/%b/%0d", i, q, sticky, e, dir_q[i], dir_s[i], dir_e[i]);
      end
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        errors++;
        $display("FAIL dir%0d fields got %h want %h", i, got(), x);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if ({busy, vld} !== 2'b00) begin
        errors++;
        $display("FAIL dir%0d after ack busy/vld got %b want 00", i, {busy, vld});
      end
    end
  endtask
  task automatic test_neither();
    int n;
    res_t x;
    issue(1'b0, 1'b0, 32'h4000000, 24'h800000, 13'd1, 13'd2);
    tick();
    pd = 1'b0;
    wait_done(n);
    x = sb.pop_front();
    checks++;
    if (n !== 26 || {q, sticky, osign, orm, olfn, odiv} !== {26'h0, 1'b0, x.sign, x.rm, x.lfn, 1'b0}) begin
      errors++;
      $display("FAIL neither latency %0d q %h sticky %b want 26 0 0", n, q, sticky);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask
  task automatic test_kill();
    int n;
    logic seen;
    res_t x;
    issue(1'b1, 1'b0, 32'h4000000, 24'hC00000, 13'd127, 13'd127);
    tick();
    pd = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    pd = 1'b1;
    tick();
    kill = 1'b0;
    pd = 1'b0;
    checks++;
    if ({busy, vld} !== 2'b00) begin
      errors++;
      $display("FAIL kill state busy/vld got %b want 00", {busy, vld});
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= vld | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL kill no_result got %b want 0", seen);
    end
    sb.delete(0);
    issue(1'b1, 1'b0, 32'h4000000, 24'h800000, 13'd127, 13'd127);
    ack = 1'b1;
    tick();
    pd = 1'b0;
    repeat (9) tick();
    ack = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL kill_restart latency got %0d want 17", n);
    end
    x = sb.pop_front();
    checks++;
    if (got() !== x) begin
      errors++;
      $display("FAIL kill_restart fields got %h want %h", got(), x);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask
  task automatic test_back_to_back();
    int n;
    res_t x;
    issue(1'b0, 1'b1, 32'h4000000, 24'h0, 13'd128, 13'd127);
    tick();
    pd = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 26) begin
      errors++;
      $display("FAIL b2b first latency got %0d want 26", n);
    end
    x = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({vld, got()} !== {1'b1, x}) begin
        errors++;
        $display("FAIL b2b hold%0d got %h want %h", i, {vld, got()}, {1'b1, x});
      end
      tick();
    end
    ack = 1'b1;
    issue(1'b0, 1'b1, 32'h2000000, 24'h0, 13'd129, 13'd127);
    tick();
    ack = 1'b0;
    pd = 1'b0;
    checks++;
    if ({busy, vld} !== 2'b10) begin
      errors++;
      $display("FAIL b2b restart busy/vld got %b want 10", {busy, vld});
    end
    wait_done(n);
    checks++;
    if (n !== 26) begin
      errors++;
      $display("FAIL b2b second latency got %0d want 26", n);
    end
    x = sb.pop_front();
    checks++;
    if (got() !== x) begin
      errors++;
      $display("FAIL b2b second fields got %h want %h", got(), x);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask
  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 32'h7FFFFF8, 24'h800001, 13'd200, 13'd3);
    tick();
    pd = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, vld, got()} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h want 0", {busy, vld, got()});
    end
    rst_n = 1'b1;
    sb.delete(0);
    tick();
  endtask
  task automatic test_random();
    int n;
    logic md;
    logic [31:0] r0;
    logic [23:0] dd;
    res_t x;
    for (int k = 0; k < 1500; k++) begin
      md = 1'($urandom);
      if (md) begin
        r0 = {5'b0, 1'b1, 23'($urandom), 3'b000};
        dd = {1'b1, 23'($urandom)};
      end else begin
        r0 = $urandom_range(32'h7FFFFFF, 32'h2000000);
        dd = 24'($urandom);
      end
      issue(md, !md, r0, dd, 13'($urandom), 13'($urandom));
      tick();
      pd = 1'b0;
      wait_done(n);
      checks++;
      if (n !== 26) begin
        errors++;
        $display("FAIL rand%0d latency got %0d want 26", k, n);
      end
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        errors++;
        $display("FAIL rand%0d r0 %h d %h div %b got %h want %h", k, r0, dd, md, got(), x);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_neither();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
